keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  Scans a 4x4 matrix keypad, debounces it and encodes it into a 4-bit key code with an active-low valid level.
//  Sits directly upstream of the lock FSM: its key_code/key_validn are what the lock FSM synchronises, captures and acts on.
//  N-key lockout: only one key is reported per press; '*' encodes 4'hF, '#' encodes 4'hE.
// PARAMETERS
//  DWELL_CYCLES     2500       clocks each column is driven before its rows are sampled (50 us)
//  DEBOUNCE_CYCLES  1_000_000  consecutive stable clocks needed to accept a press or a release (20 ms)
//  REPEAT_DELAY     25_000_000 clocks held before the first auto-repeat (KEYPAD_REPEAT_EN only)
//  REPEAT_RATE      10_000_000 clocks between later auto-repeats (KEYPAD_REPEAT_EN only)
// PORTS
//  MAX10_CLK1_50  in   1  system clock, 50 MHz
//  nreset         in   1  reset: synchronous, active-low; clock MAX10_CLK1_50
//  row_n          in   4  keypad rows, active-low, pulled up off-chip, asynchronous
//  col_n          out  4  column drive, active-low, one-hot-zero
//  key_code       out  4  encoded key, stable whenever key_validn=0
//  key_validn     out  1  0 while a debounced key is held
//  key_strobe     out  1  one-cycle pulse for each accepted key event
// BEHAVIOUR
//  Reset values: col_n=4'b1110, key_code=4'h0, key_validn=1, key_strobe=0, state=SCAN, all counters 0.
//  row_n is passed through a 2-FF synchroniser; all decisions use the synchronised rows (rs).
//  Key map, row r / col c:
//   r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: F(*) 0 E(#) D
//  FSM:
//   SCAN
//    - Drive column c. On the last dwell cycle, sample rs.
//    - No row low: rotate c -> c+1 (3 wraps to 0).
//    - Any row low: latch (r,c), using the lowest-index low row when several rows are low.
//      Load key_code from the map, hold column c, clear the counter, go to DB_PRESS.
//   DB_PRESS
//    - rs[r] high: back to SCAN, counter cleared; key_code keeps its new value and key_validn stays 1.
//    - Counter reaches DEBOUNCE_CYCLES-1: go to HELD, key_validn<=0, key_strobe=1 for that cycle.
//   HELD
//    - rs[r] high: go to DB_REL with the counter cleared.
//    - Every other row and column is ignored (lockout).
//   DB_REL
//    - rs[r] low: go back to HELD with no new strobe.
//    - Counter reaches DEBOUNCE_CYCLES-1: key_validn<=1, then resume SCAN at column c+1.
//  Latency:
//   - key_code is valid at least DEBOUNCE_CYCLES clocks before key_validn falls.
//   - key_code never changes while key_validn=0.
//   - key_validn stays high for at least DWELL_CYCLES clocks between events.
//  Counters saturate and never wrap. A glitch of any length resets the relevant debounce count.
//  Reset mid-press: everything returns to reset values, and the key must be re-debounced from SCAN.
// CONFIGURATION
//  `KEYPAD_REPEAT_EN defined:
//   - In HELD, once the key has been held REPEAT_DELAY clocks, key_validn goes to 1 for 8 clocks, then back to 0 with a key_strobe pulse.
//   - Further repeats follow every REPEAT_RATE clocks while the key is held.
//   - Entering DB_REL cancels the repeat timer.
//  Not defined: exactly one event per physical press; the repeat timer and its parameters are unused and not synthesised.
// STRUCTURE
//  keypad_pkg:
//   - scan_state_t enum {SCAN, DB_PRESS, HELD, DB_REL}
//   - KEY_STAR=4'hF, KEY_HASH=4'hE
//   - 4x4 key map constant and function map_key(row,col)
//  Sub-module keypad_sync: 2-FF synchroniser, width parameter, used for row_n.
//  Dwell, debounce and repeat counters are separate registers in keypad_scanner.
// TESTING (sim with DWELL_CYCLES=4, DEBOUNCE_CYCLES=16, REPEAT_DELAY=64, REPEAT_RATE=32)
//  1. Reset: nreset=0 for 3 clocks -> col_n=1110, key_validn=1, key_code=0, key_strobe=0.
//  2. Hold row1 low whenever col2 is driven, for 40 clocks
//     -> key_code=4'h6, then key_validn=0 plus one key_strobe; release -> key_validn=1 after 16+ clocks.
//  3. Press '*' (r3,c0) and '#' (r3,c2) in turn
//     -> key_code 4'hF then 4'hE, two strobes, key_validn high between them.
//  4. Bounce on press (toggle every 5 clocks for 30 clocks, then steady)
//     -> exactly one strobe, no early key_validn fall.
//     Bounce on release (3-clock highs) -> key_validn stays 0.
//  5. Hold '5', then add '9' -> key_code stays 4'h5.
//     Release '5' with '9' still held -> key_validn=1, then a new event with 4'h9.
//  6. nreset=0 while in HELD -> key_validn=1 next clock.
//     With KEYPAD_REPEAT_EN: a 200-clock hold gives strobes at about 0, 64, 96, 128, 160 (1 without the macro).

Source files
------------

// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_pkg
//  Description : Shared types, key codes and 4x4 key map for the keypad scanner.
//  Revision    : 1.0  initial release
// ============================================================================
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DB_PRESS = 2'd1,
        HELD     = 2'd2,
        DB_REL   = 2'd3
    } scan_state_t;

    localparam logic [3:0] KEY_STAR = 4'hF;
    localparam logic [3:0] KEY_HASH = 4'hE;

    // Nibble {row,col} holds the code of that key. Rows top to bottom:
    // 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
    localparam logic [63:0] c_KEY_MAP = {4'hD, KEY_HASH, 4'h0, KEY_STAR,
                                         4'hC, 4'h9,     4'h8, 4'h7,
                                         4'hB, 4'h6,     4'h5, 4'h4,
                                         4'hA, 4'h3,     4'h2, 4'h1};

    function automatic logic [3:0] map_key(input logic [1:0] row, input logic [1:0] col);
        logic [5:0] w_idx;
        w_idx = {row, col, 2'b00};
        return c_KEY_MAP[w_idx +: 4];
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scanner_if.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scanner_if
//  Description : Keypad matrix and encoded-key bundle. The master is the
//                scanner; the slave is the keypad/consumer side.
//  Revision    : 1.0  initial release
// ============================================================================
interface keypad_scanner_if;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_validn;
    logic       key_strobe;

    modport master (
        input  row_n,
        output col_n,
        output key_code,
        output key_validn,
        output key_strobe
    );

    modport slave (
        output row_n,
        input  col_n,
        input  key_code,
        input  key_validn,
        input  key_strobe
    );
endinterface
`default_nettype wire

// File: rtl/keypad_sync.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_sync
//  Description : Two-flop synchroniser for asynchronous level inputs.
//                Resets to RESET_VAL (all ones: idle pulled-up rows).
//  Revision    : 1.0  initial release
// ============================================================================
module keypad_sync #(
    parameter int unsigned          WIDTH     = 4,
    parameter logic [WIDTH-1:0]     RESET_VAL = '1
) (
    input  wire              MAX10_CLK1_50,
    input  wire              nreset,
    input  wire [WIDTH-1:0]  i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two register stages to let metastability resolve
    always_ff @(posedge MAX10_CLK1_50) begin
        if (!nreset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scanner
//  Description : 4x4 matrix keypad scanner with debounce, N-key lockout and
//                4-bit key encoding ('*'=F, '#'=E). Optional auto-repeat is
//                built when the KEYPAD_REPEAT_EN macro is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES    = 2500,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_DELAY    = 25_000_000,
    parameter int unsigned REPEAT_RATE     = 10_000_000
) (
    input  wire                MAX10_CLK1_50,
    input  wire                nreset,
    keypad_scanner_if.master   kp
);
    localparam int c_DW_W = $clog2(DWELL_CYCLES + 1);
    localparam int c_DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_DW_W-1:0] c_DW_LAST = c_DW_W'(DWELL_CYCLES - 1);
    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYCLES - 1);

    scan_state_t       r_state;
    logic [1:0]        r_col;
    logic [1:0]        r_row;
    logic [c_DW_W-1:0] r_dwell;
    logic [c_DB_W-1:0] r_db;
    logic [3:0]        r_code;
    logic              r_validn;
    logic              r_strobe;

    logic [3:0]        w_rs;
    logic              w_any_low;
    logic [1:0]        w_row;
    logic              w_key_low;

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned c_RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int c_RPT_W = $clog2(c_RPT_MAX + 1);
    localparam logic [c_RPT_W-1:0] c_DELAY_LAST = c_RPT_W'(REPEAT_DELAY - 1);
    localparam logic [c_RPT_W-1:0] c_RATE_LAST  = c_RPT_W'(REPEAT_RATE - 1);

    logic [c_RPT_W-1:0] r_rpt;
    logic               r_rpt_first;
    logic               r_gap_on;
    logic [2:0]         r_gap;
    logic [c_RPT_W-1:0] w_rpt_last;

    assign w_rpt_last = r_rpt_first ? c_DELAY_LAST : c_RATE_LAST;
`else
    logic w_unused_rpt;
    assign w_unused_rpt = ^{REPEAT_DELAY, REPEAT_RATE};
`endif

    keypad_sync #(
        .WIDTH     (4),
        .RESET_VAL (4'hF)
    ) u_row_sync (
        .MAX10_CLK1_50 (MAX10_CLK1_50),
        .nreset        (nreset),
        .i_d           (kp.row_n),
        .o_q           (w_rs)
    );

    // Lowest-index low row wins when several rows are pressed at once
    always_comb begin
        w_row = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!w_rs[i]) w_row = 2'(i);
        end
    end

    assign w_any_low = ~&w_rs;
    assign w_key_low = ~w_rs[r_row];

    // Scan / debounce / hold / release state machine
    always_ff @(posedge MAX10_CLK1_50) begin
        if (!nreset) begin
            r_state  <= SCAN;
            r_col    <= 2'd0;
            r_row    <= 2'd0;
            r_dwell  <= '0;
            r_db     <= '0;
            r_code   <= 4'h0;
            r_validn <= 1'b1;
            r_strobe <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            r_rpt       <= '0;
            r_rpt_first <= 1'b1;
            r_gap_on    <= 1'b0;
            r_gap       <= 3'd0;
`endif
        end else begin
            r_strobe <= 1'b0;
            case (r_state)
                SCAN: begin
                    if (r_dwell == c_DW_LAST) begin
                        r_dwell <= '0;
                        if (w_any_low) begin
                            r_row   <= w_row;
                            r_code  <= map_key(w_row, r_col);
                            r_db    <= '0;
                            r_state <= DB_PRESS;
                        end else begin
                            r_col <= r_col + 2'd1;
                        end
                    end else begin
                        r_dwell <= r_dwell + c_DW_W'(1);
                    end
                end

                DB_PRESS: begin
                    if (!w_key_low) begin
                        // Bounce: restart scanning the same column
                        r_state <= SCAN;
                        r_db    <= '0;
                    end else if (r_db == c_DB_LAST) begin
                        r_state  <= HELD;
                        r_validn <= 1'b0;
                        r_strobe <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
                        r_rpt       <= '0;
                        r_rpt_first <= 1'b1;
                        r_gap_on    <= 1'b0;
`endif
                    end else begin
                        r_db <= r_db + c_DB_W'(1);
                    end
                end

                HELD: begin
                    if (!w_key_low) begin
                        r_state <= DB_REL;
                        r_db    <= '0;
`ifdef KEYPAD_REPEAT_EN
                        // Release cancels the repeat timer and any gap in progress
                        r_rpt    <= '0;
                        r_gap_on <= 1'b0;
                        r_validn <= 1'b0;
`endif
                    end
`ifdef KEYPAD_REPEAT_EN
                    else begin
                        if (r_gap_on) begin
                            if (r_gap == 3'd7) begin
                                r_gap_on <= 1'b0;
                                r_validn <= 1'b0;
                                r_strobe <= 1'b1;
                            end else begin
                                r_gap <= r_gap + 3'd1;
                            end
                        end
                        if (r_rpt == w_rpt_last) begin
                            r_rpt       <= '0;
                            r_rpt_first <= 1'b0;
                            r_validn    <= 1'b1;
                            r_gap_on    <= 1'b1;
                            r_gap       <= 3'd0;
                        end else begin
                            r_rpt <= r_rpt + c_RPT_W'(1);
                        end
                    end
`endif
                end

                DB_REL: begin
                    if (w_key_low) begin
                        // Release bounce: back to held, no new event
                        r_state <= HELD;
                        r_db    <= '0;
`ifdef KEYPAD_REPEAT_EN
                        r_rpt       <= '0;
                        r_rpt_first <= 1'b1;
`endif
                    end else if (r_db == c_DB_LAST) begin
                        r_validn <= 1'b1;
                        r_state  <= SCAN;
                        r_col    <= r_col + 2'd1;
                        r_dwell  <= '0;
                    end else begin
                        r_db <= r_db + c_DB_W'(1);
                    end
                end

                default: r_state <= SCAN;
            endcase
        end
    end

    assign kp.col_n      = ~(4'b0001 << r_col);
    assign kp.key_code   = r_code;
    assign kp.key_validn = r_validn;
    assign kp.key_strobe = r_strobe;
endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_scanner
//  Description : Self-checking bench for keypad_scanner with a physical
//                keypad model (pressed-key matrix plus contact bounce).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_keypad_scanner;
    logic clk = 1'b0;
    logic nreset = 1'b0;
    always #5 clk = ~clk;

    keypad_scanner_if kp_if();

    keypad_scanner #(
        .DWELL_CYCLES    (4),
        .DEBOUNCE_CYCLES (16),
        .REPEAT_DELAY    (64),
        .REPEAT_RATE     (32)
    ) dut (
        .MAX10_CLK1_50 (clk),
        .nreset        (nreset),
        .kp            (kp_if)
    );

    // Physical keypad: held[r*4+c] closes row r onto column c; glitch opens all contacts
    logic [15:0] held   = 16'h0;
    logic        glitch = 1'b0;
    logic [3:0]  rows;
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (held[r*4+c] && !kp_if.col_n[c]) rows[r] = 1'b0;
        if (glitch) rows = 4'hF;
    end
    assign kp_if.row_n = rows;

    logic [3:0] exp_map [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                                 4'h7, 4'h8, 4'h9, 4'hC, 4'hF, 4'h0, 4'hE, 4'hD};

    int n_tests = 0;
    int n_fail  = 0;

    // Event monitor
    int   strobe_cnt = 0;
    int   code_viol  = 0;
    int   strobe_bad = 0;
    int   early_fall = 0;
    int   late_rise  = 0;
    logic watch_high = 1'b0;
    logic watch_low  = 1'b0;
    logic [3:0] prev_code = 4'h0;
    logic       prev_validn = 1'b1;
    always @(negedge clk) begin
        if (kp_if.key_strobe === 1'b1) begin
            strobe_cnt++;
            if (kp_if.key_validn !== 1'b0) strobe_bad++;
        end
        if (nreset && !kp_if.key_validn && !prev_validn && kp_if.key_code !== prev_code) code_viol++;
        if (watch_high && kp_if.key_validn !== 1'b1) early_fall++;
        if (watch_low && kp_if.key_validn !== 1'b0) late_rise++;
        prev_code   = kp_if.key_code;
        prev_validn = kp_if.key_validn;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_strobes(input string tag, input int target);
        int i;
        for (i = 0; i < 300 && strobe_cnt < target; i++) tick(1);
        check({tag, "_strobe_seen"}, 32'(strobe_cnt >= target), 1);
    endtask

    task automatic wait_release(input string tag, output int cycles);
        cycles = 0;
        while (kp_if.key_validn !== 1'b1 && cycles < 300) begin
            tick(1);
            cycles++;
        end
        check({tag, "_released"}, 32'(kp_if.key_validn), 1);
    endtask

    // Press the given keys, wait for exactly one event and check its code
    task automatic press(input string tag, input logic [15:0] keys, input logic [3:0] exp_code);
        int base;
        base = strobe_cnt;
        held = keys;
        wait_strobes(tag, base + 1);
        check({tag, "_code"},   32'(kp_if.key_code), 32'(exp_code));
        check({tag, "_validn"}, 32'(kp_if.key_validn), 0);
        check({tag, "_count"},  32'(strobe_cnt - base), 1);
    endtask

    initial begin
        int cyc;
        int base;
        int k, r1, r2, c, rlo;

        // 1. Reset
        nreset = 1'b0;
        tick(3);
        check("rst_col_n",  32'(kp_if.col_n), 32'h E);
        check("rst_validn", 32'(kp_if.key_validn), 1);
        check("rst_code",   32'(kp_if.key_code), 0);
        check("rst_strobe", 32'(kp_if.key_strobe), 0);
        nreset = 1'b1;
        tick(2);

        // 2. Key '6' (row1, col2)
        press("key6", 16'h0040, 4'h6);
        tick(20);
        held = 16'h0;
        wait_release("key6", cyc);
        check("key6_rel_time", 32'(cyc >= 16), 1);

        // 3. '*' then '#'
        tick(3);
        press("star", 16'h1000, 4'hF);
        held = 16'h0;
        wait_release("star", cyc);
        check("between_validn", 32'(kp_if.key_validn), 1);
        press("hash", 16'h4000, 4'hE);
        held = 16'h0;
        wait_release("hash", cyc);

        // 4. Press bounce then release bounce on '8'
        base = strobe_cnt;
        held = 16'h0200;
        watch_high = 1'b1;
        for (int i = 0; i < 6; i++) begin
            glitch = i[0];
            tick(5);
        end
        glitch = 1'b0;
        watch_high = 1'b0;
        check("bounce_no_early_fall", 32'(early_fall), 0);
        wait_strobes("bounce", base + 1);
        check("bounce_code", 32'(kp_if.key_code), 32'h8);
        tick(1);
        watch_low = 1'b1;
        for (int i = 0; i < 4; i++) begin
            glitch = 1'b1;
            tick(3);
            glitch = 1'b0;
            tick(5);
        end
        tick(4);
        watch_low = 1'b0;
        check("rel_bounce_held", 32'(late_rise), 0);
        held = 16'h0;
        wait_release("bounce", cyc);
        check("bounce_one_strobe", 32'(strobe_cnt - base), 1);

        // 5. Lockout: hold '5', add '9', release '5'
        tick(3);
        press("key5", 16'h0020, 4'h5);
        base = strobe_cnt;
        held = 16'h0420;
        tick(30);
        check("lockout_code", 32'(kp_if.key_code), 32'h5);
        check("lockout_no_strobe", 32'(strobe_cnt - base), 0);
        held = 16'h0400;
        wait_release("key5", cyc);
        wait_strobes("key9", base + 1);
        check("key9_code", 32'(kp_if.key_code), 32'h9);
        held = 16'h0;
        wait_release("key9", cyc);

        // 6. Reset while held, then re-debounce and long hold
        tick(3);
        press("keyD", 16'h8000, 4'hD);
        tick(5);
        nreset = 1'b0;
        tick(1);
        check("midrst_validn", 32'(kp_if.key_validn), 1);
        check("midrst_code",   32'(kp_if.key_code), 0);
        check("midrst_col_n",  32'(kp_if.col_n), 32'hE);
        nreset = 1'b1;
        press("keyD_again", 16'h8000, 4'hD);
        base = strobe_cnt;
        tick(180);
`ifdef KEYPAD_REPEAT_EN
        check("repeat_strobes", 32'(strobe_cnt - base), 4);
`else
        check("repeat_strobes", 32'(strobe_cnt - base), 0);
`endif
        held = 16'h0;
        wait_release("keyD", cyc);

        // Randomised presses against the key-map model
        for (int it = 0; it < 12; it++) begin
            tick($urandom_range(1, 12));
            if ($urandom_range(0, 1) == 0) begin
                k = $urandom_range(0, 15);
                press("rnd_single", 16'(1) << k, exp_map[k]);
            end else begin
                c  = $urandom_range(0, 3);
                r1 = $urandom_range(0, 3);
                r2 = (r1 + $urandom_range(1, 3)) % 4;
                rlo = (r1 < r2) ? r1 : r2;
                press("rnd_dual", (16'(1) << (r1*4+c)) | (16'(1) << (r2*4+c)), exp_map[rlo*4+c]);
            end
            tick($urandom_range(0, 30));
            held = 16'h0;
            wait_release("rnd", cyc);
        end

        check("code_stable_while_valid", 32'(code_viol), 0);
        check("strobe_with_validn_low", 32'(strobe_bad), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
